alu_seq: RTL and testbench

- Parametrised, sequential successor to the 8-bit combinational ALU of the 12-bit microcontroller datapath.
- Operand width is set by a parameter, and operands, mode and incoming flags are registered on a Start/Ready handshake.
- Logic and arithmetic ops complete in one cycle; shifts, rotates and multiply run iteratively.
- Produces a registered Result plus a corrected {Z,C,S,O} flag set, with a one-cycle Done pulse.

---
 rtl/alu_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential parametrised ALU: single-cycle logic/arithmetic ops, iterative
// shift/rotate (one bit per cycle) and shift-add multiply, with {Z,C,S,O} flags.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Enable,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       Mode,
    input  logic [3:0]       Cflags,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               ready_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic [3:0]         flags_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [3:0]         mode_r;
    logic               cfo_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] prod_r;

    logic               accept_s;
    logic [SHW-1:0]     amt_s;
    logic               shift_mode_s;
    logic [WIDTH+1:0]   arith_s;
    logic [WIDTH-1:0]   qres_s;
    logic               qc_s;
    logic               qo_s;
    logic [3:0]         qflg_s;
    logic [WIDTH-1:0]   step_b_s;
    logic               step_out_s;
    logic [WIDTH:0]     madd_s;
    logic [2*WIDTH-1:0] mul_nxt_s;
    logic               mul_hi_s;
    logic               unused_s;

    // Returns {carry_or_borrow, overflow, result}; borrow is the top bit of the widened difference.
    function automatic logic [WIDTH+1:0] arith(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sub);
        logic [WIDTH:0] r;
        logic           ov;
        if (sub) begin
            r  = {1'b0, x} - {1'b0, y};
            ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else begin
            r  = {1'b0, x} + {1'b0, y};
            ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end
        return {r[WIDTH], ov, r[WIDTH-1:0]};
    endfunction

    assign accept_s     = Start & ready_r & Enable;
    assign amt_s        = Operand1[SHW-1:0];
    assign shift_mode_s = (Mode >= 4'd10) && (Mode <= 4'd14);
    assign unused_s     = ^{Cflags[3], Cflags[1]};

    assign Ready  = ready_r;
    assign Done   = done_r;
    assign Result = result_r;
    assign Flags  = flags_r;

    // State register; Enable low freezes the FSM.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= IDLE;
        end else if (Enable) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state logic; the iterative states leave on the last counted step.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = IDLE;
                end else if (Mode == 4'd15) begin
                    state_nxt_s = MUL;
                end else if (shift_mode_s && (amt_s != {SHW{1'b0}})) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            SHIFT, MUL: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Single-cycle result and flags straight from the inputs at accept (zero-length shifts pass B).
    always_comb begin
        arith_s = {(WIDTH+2){1'b0}};
        qres_s  = Operand2;
        qc_s    = Cflags[2];
        qo_s    = Cflags[0];
        case (Mode)
            4'd0:    arith_s = arith(Operand1, Operand2, 1'b0);
            4'd1:    arith_s = arith(Operand1, Operand2, 1'b1);
            4'd7:    arith_s = arith(Operand2, Operand1, 1'b1);
            4'd8:    arith_s = arith(Operand1, ONE, 1'b0);
            4'd9:    arith_s = arith(Operand1, ONE, 1'b1);
            default: arith_s = {(WIDTH+2){1'b0}};
        endcase
        case (Mode)
            4'd0, 4'd1, 4'd7, 4'd8, 4'd9: begin
                qres_s = arith_s[WIDTH-1:0];
                qc_s   = arith_s[WIDTH+1];
                qo_s   = arith_s[WIDTH];
            end
            4'd2:    qres_s = Operand1;
            4'd3:    qres_s = Operand2;
            4'd4:    qres_s = Operand1 & Operand2;
            4'd5:    qres_s = Operand1 | Operand2;
            4'd6:    qres_s = Operand1 ^ Operand2;
            default: qres_s = Operand2;
        endcase
        qflg_s = {(qres_s == {WIDTH{1'b0}}), qc_s, qres_s[WIDTH-1], qo_s};
    end

    // One-bit shift/rotate step on the captured B and the bit it pushes out.
    always_comb begin
        step_b_s   = b_r;
        step_out_s = 1'b0;
        case (mode_r)
            4'd10: begin
                step_b_s   = {b_r[WIDTH-2:0], b_r[WIDTH-1]};
                step_out_s = b_r[WIDTH-1];
            end
            4'd11: begin
                step_b_s   = {b_r[0], b_r[WIDTH-1:1]};
                step_out_s = b_r[0];
            end
            4'd12: begin
                step_b_s   = {b_r[WIDTH-2:0], 1'b0};
                step_out_s = b_r[WIDTH-1];
            end
            4'd13: begin
                step_b_s   = {1'b0, b_r[WIDTH-1:1]};
                step_out_s = b_r[0];
            end
            4'd14: begin
                step_b_s   = {b_r[WIDTH-1], b_r[WIDTH-1:1]};
                step_out_s = b_r[0];
            end
            default: begin
                step_b_s   = b_r;
                step_out_s = 1'b0;
            end
        endcase
    end

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        if (prod_r[0]) begin
            madd_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, a_r};
        end else begin
            madd_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        mul_nxt_s = {madd_s, prod_r[WIDTH-1:1]};
        mul_hi_s  = (mul_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end

    // Operand capture, iteration registers and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            mode_r   <= 4'd0;
            cfo_r    <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
        end else if (Enable) begin
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r    <= Operand1;
                        b_r    <= Operand2;
                        mode_r <= Mode;
                        cfo_r  <= Cflags[0];
                        prod_r <= {{WIDTH{1'b0}}, Operand2};
                        cnt_r  <= (Mode == 4'd15) ? CW'(WIDTH) : {1'b0, amt_s};
                        if (state_nxt_s == DONE) begin
                            result_r <= qres_s;
                            flags_r  <= qflg_s;
                        end
                    end
                end
                SHIFT: begin
                    b_r   <= step_b_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        result_r <= step_b_s;
                        flags_r  <= {(step_b_s == {WIDTH{1'b0}}), step_out_s,
                                     step_b_s[WIDTH-1], cfo_r};
                    end
                end
                MUL: begin
                    prod_r <= mul_nxt_s;
                    cnt_r  <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        result_r <= mul_nxt_s[WIDTH-1:0];
                        flags_r  <= {(mul_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}}), mul_hi_s,
                                     mul_nxt_s[WIDTH-1], mul_hi_s};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, hand-written
// stall/reset sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         start;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   mode;
    logic [3:0]   cflags;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] m;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cf;
        logic [7:0] res;
        logic [3:0] flg;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    alu_seq #(.WIDTH(W)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Enable   (enable),
        .Start    (start),
        .Operand1 (op1),
        .Operand2 (op2),
        .Mode     (mode),
        .Cflags   (cflags),
        .Ready    (ready),
        .Done     (done),
        .Result   (result),
        .Flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model computed from the operation definitions with plain integer arithmetic.
    function automatic void model(input logic [3:0] m, input logic [7:0] a8, input logic [7:0] b8,
                                  input logic [3:0] cf, output logic [7:0] r8,
                                  output logic [3:0] f, output int lat);
        longint a, b, x, y, full, res, sb;
        int     n, kind;
        logic   c, o;
        a = a8; b = b8; n = int'(a8[2:0]);
        c = cf[2]; o = cf[0]; lat = 1; res = 0; kind = 2; x = 0; y = 0; full = 0; sb = 0;
        case (m)
            4'd0: begin x = a; y = b; kind = 0; end
            4'd1: begin x = a; y = b; kind = 1; end
            4'd7: begin x = b; y = a; kind = 1; end
            4'd8: begin x = a; y = 1; kind = 0; end
            4'd9: begin x = a; y = 1; kind = 1; end
            4'd2: res = a;
            4'd3: res = b;
            4'd4: res = a & b;
            4'd5: res = a | b;
            4'd6: res = a ^ b;
            4'd15: begin
                full = a * b;
                res  = full % 256;
                c    = (full / 256) != 0;
                o    = c;
                lat  = W + 1;
            end
            default: begin
                res = b;
                if (n > 0) begin
                    lat = n + 1;
                    case (m)
                        4'd10: begin res = ((b << n) | (b >> (W - n))) % 256; c = (res % 2) != 0; end
                        4'd11: begin res = ((b >> n) | (b << (W - n))) % 256; c = res >= 128; end
                        4'd12: begin res = (b << n) % 256; c = ((b >> (W - n)) % 2) != 0; end
                        4'd13: begin res = b >> n; c = ((b >> (n - 1)) % 2) != 0; end
                        default: begin
                            sb  = (b >= 128) ? b - 256 : b;
                            res = (sb >>> n) & 255;
                            c   = ((sb >>> (n - 1)) & 1) != 0;
                        end
                    endcase
                end
            end
        endcase
        if (kind == 0) begin
            full = x + y;
            res  = full % 256;
            c    = full > 255;
            o    = ((x / 128) == (y / 128)) && ((res / 128) != (x / 128));
        end else if (kind == 1) begin
            res = (x - y + 256) % 256;
            c   = x < y;
            o   = ((x / 128) != (y / 128)) && ((res / 128) != (x / 128));
        end
        r8 = 8'(res);
        f  = {res == 0, c, res >= 128, o};
    endfunction

    // Issue one operation, scramble the inputs after accept, and measure latency to Done.
    task automatic do_op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] cf, output logic [7:0] r, output logic [3:0] f,
                         output int lat);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("ready_idle", 64'(ready), 64'd1);
        mode = m; op1 = a; op2 = b; cflags = cf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op1 = 8'($urandom); op2 = 8'($urandom); mode = 4'($urandom); cflags = 4'($urandom);
        chk("ready_busy", 64'(ready), 64'd0);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = result;
        f = flags;
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        logic [7:0] r, er;
        logic [3:0] f, ef;
        int         lat, elat;

        vecs[0]  = '{4'd0,  8'h7F, 8'h01, 4'b0000, 8'h80, 4'b0011, 1};
        vecs[1]  = '{4'd1,  8'h10, 8'h20, 4'b0000, 8'hF0, 4'b0110, 1};
        vecs[2]  = '{4'd1,  8'h55, 8'h55, 4'b0000, 8'h00, 4'b1000, 1};
        vecs[3]  = '{4'd10, 8'h03, 8'h81, 4'b0000, 8'h0C, 4'b0000, 4};
        vecs[4]  = '{4'd15, 8'h10, 8'h12, 4'b0000, 8'h20, 4'b0101, 9};
        vecs[5]  = '{4'd15, 8'h00, 8'hFF, 4'b0000, 8'h00, 4'b1000, 9};
        vecs[6]  = '{4'd2,  8'h00, 8'h33, 4'b0101, 8'h00, 4'b1101, 1};
        vecs[7]  = '{4'd11, 8'h08, 8'h3C, 4'b0100, 8'h3C, 4'b0100, 1};
        vecs[8]  = '{4'd9,  8'h00, 8'h77, 4'b0000, 8'hFF, 4'b0110, 1};
        vecs[9]  = '{4'd8,  8'hFF, 8'h00, 4'b0000, 8'h00, 4'b1100, 1};
        vecs[10] = '{4'd13, 8'h01, 8'h01, 4'b0000, 8'h00, 4'b1100, 2};
        vecs[11] = '{4'd7,  8'h01, 8'h80, 4'b0000, 8'h7F, 4'b0001, 1};
        vecs[12] = '{4'd6,  8'hF0, 8'hFF, 4'b1111, 8'h0F, 4'b0101, 1};

        rst_n = 1'b0; enable = 1'b1; start = 1'b0;
        op1 = 8'h00; op2 = 8'h00; mode = 4'd0; cflags = 4'd0;
        @(posedge clk); #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags",  64'(flags),  64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_ready",  64'(ready),  64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].cf, r, f, lat);
            chk($sformatf("vec%0d_res", i), 64'(r),   64'(vecs[i].res));
            chk($sformatf("vec%0d_flg", i), 64'(f),   64'(vecs[i].flg));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // SAR by 7 with a two-cycle stall mid-shift and a Start pulse while busy.
        mode = 4'd14; op1 = 8'h07; op2 = 8'h80; cflags = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 2) enable = 1'b0;
            if (lat == 4) begin
                enable = 1'b1; start = 1'b1; mode = 4'd0; op1 = 8'h01; op2 = 8'h01;
            end
            if (lat == 5) start = 1'b0;
            @(posedge clk); #1; lat++;
        end
        start = 1'b0; enable = 1'b1;
        chk("sar_lat", 64'(lat),    64'd10);
        chk("sar_res", 64'(result), 64'hFF);
        chk("sar_flg", 64'(flags),  64'b0010);
        @(posedge clk); #1;
        chk("sar_done_low", 64'(done),  64'd0);
        chk("sar_ready",    64'(ready), 64'd1);
        @(posedge clk); #1;
        chk("busy_start_ignored", 64'(done),   64'd0);
        chk("busy_start_hold",    64'(result), 64'hFF);

        // Reset in the third cycle of a multiply.
        mode = 4'd15; op1 = 8'h10; op2 = 8'h12; cflags = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_flags",  64'(flags),  64'd0);
        chk("mrst_done",   64'(done),   64'd0);
        chk("mrst_ready",  64'(ready),  64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'd0, 8'h01, 8'h01, 4'd0, r, f, lat);
        chk("post_rst_res", 64'(r),   64'h02);
        chk("post_rst_flg", 64'(f),   64'b0000);
        chk("post_rst_lat", 64'(lat), 64'd1);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] m, cf;
            logic [7:0] a, b;
            m = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom); cf = 4'($urandom);
            model(m, a, b, cf, er, ef, elat);
            do_op(m, a, b, cf, r, f, lat);
            chk($sformatf("rnd%0d_m%0d_res", i, m), 64'(r),   64'(er));
            chk($sformatf("rnd%0d_m%0d_flg", i, m), 64'(f),   64'(ef));
            chk($sformatf("rnd%0d_m%0d_lat", i, m), 64'(lat), 64'(elat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
